codec_reg_packetizer: RTL

CODEC_REG_PACKETIZER -- requirements
Module: codec_reg_packetizer

---
 rtl/codec_reg_packetizer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/codec_reg_packetizer.sv
// codec_reg_packetizer
// Turns a single codec register-write request (7-bit register address,
// 9-bit value) into a short AXI-Stream packet for an I2C master's data FIFO:
//   [ {DEV_ADDR,1'b0} ]  {addr[6:0],data[8]}  data[7:0] (tlast)
// The bracketed device-address byte exists only when the build macro
// CODEC_PKT_DEV_ADDR_EN is defined. The default build emits 2-byte packets.
// A packet counter tallies every packet whose final byte was accepted.
module codec_reg_packetizer #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic [6:0]           req_addr,
  input  logic [8:0]           req_data,
  input  logic                 req_valid,
  output logic                 req_ready,

  output logic [7:0]           output_axis_tdata,
  output logic                 output_axis_tvalid,
  input  logic                 output_axis_tready,
  output logic                 output_axis_tlast,
  output logic                 output_axis_tuser,

  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pkt_count
);

  // One state per emitted byte; IDLE is the only state that takes requests.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
`ifdef CODEC_PKT_DEV_ADDR_EN
    BYTE_DEV = 2'd1,
`endif
    BYTE_HI  = 2'd2,
    BYTE_LO  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [6:0]             r_addr;
  logic [8:0]             r_data;
  logic [CNT_WIDTH-1:0]   r_pkt_count;
  logic                   w_accept;
  logic                   w_xfer;

`ifndef CODEC_PKT_DEV_ADDR_EN
  // The device address is only placed on the wire when the extra byte is built.
  logic w_unused_dev_addr;
  assign w_unused_dev_addr = ^DEV_ADDR;
`endif

  assign req_ready         = (r_state == IDLE);
  assign busy              = (r_state != IDLE);
  assign output_axis_tuser = 1'b0;
  assign pkt_count         = r_pkt_count;

  assign w_accept = req_valid & req_ready;
  assign w_xfer   = output_axis_tvalid & output_axis_tready;

  // State register: advances only on acceptance or on a byte transfer.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and byte-lane decode; outputs depend only on registered state,
  // so they hold stable for as long as the downstream stalls.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next       = r_state;
    output_axis_tvalid = 1'b0;
    output_axis_tdata  = 8'h00;
    output_axis_tlast  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifdef CODEC_PKT_DEV_ADDR_EN
          w_state_next = BYTE_DEV;
`else
          w_state_next = BYTE_HI;
`endif
        end
      end
`ifdef CODEC_PKT_DEV_ADDR_EN
      BYTE_DEV: begin
        output_axis_tvalid = 1'b1;
        output_axis_tdata  = {DEV_ADDR, 1'b0};
        if (w_xfer) begin
          w_state_next = BYTE_HI;
        end
      end
`endif
      BYTE_HI: begin
        output_axis_tvalid = 1'b1;
        output_axis_tdata  = {r_addr, r_data[8]};
        if (w_xfer) begin
          w_state_next = BYTE_LO;
        end
      end
      BYTE_LO: begin
        output_axis_tvalid = 1'b1;
        output_axis_tdata  = r_data[7:0];
        output_axis_tlast  = 1'b1;
        if (w_xfer) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Request capture: only loaded on acceptance, so the payload is frozen
  // for the whole packet regardless of what the requester does meanwhile.
  // NOTE: the capture registers are reset along with the control state so the
  // byte lanes never expose stale data after a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= 7'h00;
      r_data <= 9'h000;
    end else if (w_accept) begin
      r_addr <= req_addr;
      r_data <= req_data;
    end
  end

  // Packet counter: bumps on the final byte's transfer, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_count <= '0;
    end else if (w_xfer && (r_state == BYTE_LO)) begin
      r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
    end
  end

endmodule
